div_restoring_ctrl: RTL and testbench

DIV_RESTORING_CTRL -- requirements
Module: div_restoring_ctrl

---
 rtl/div_restoring_ctrl.sv | 149 ++++++++++++++
 tb/tb_div_restoring_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_restoring_ctrl.sv
// rtl/div_restoring_ctrl.sv - restoring unsigned divider, one quotient bit per SHIFT/SUB pair.
// Optional zero-divisor fast path enabled by defining DIV0_FAST_EN.
module div_restoring_ctrl #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div0
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N:0]    diff;

`ifdef DIV0_FAST_EN
    logic          div0_q, div0_d;
`endif

    assign diff = a_q - {1'b0, m_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV0_FAST_EN
        div0_d  = div0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    m_d     = divisor;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                a_d     = '0;
                count_d = CW'(N);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
`ifdef DIV0_FAST_EN
                // Zero divisor skips the iterations; Q still holds the untouched dividend.
                if (m_q == '0) begin
                    quot_d  = '1;
                    rem_d   = q_q;
                    div0_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
                    state_d    = S_SUB;
                end
`else
                {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
                state_d    = S_SUB;
`endif
            end
            S_SUB: begin
                count_d = count_q - CW'(1);
                if (!diff[N]) begin
                    a_d    = diff;
                    q_d[0] = 1'b1;
                end
                if (count_q == CW'(1)) begin
                    quot_d  = q_d;
                    rem_d   = a_d[N-1:0];
`ifdef DIV0_FAST_EN
                    div0_d  = 1'b0;
`endif
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

`ifdef DIV0_FAST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div0_q <= 1'b0;
        end else begin
            div0_q <= div0_d;
        end
    end

    assign div0 = div0_q;
`else
    assign div0 = 1'b0;
`endif

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_SUB);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_div_restoring_ctrl.sv
// tb/tb_div_restoring_ctrl.sv - directed self-checking bench for div_restoring_ctrl (N=3).
module tb_div_restoring_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] dividend;
    logic [2:0] divisor;
    logic [2:0] quotient;
    logic [2:0] remainder;
    logic       busy;
    logic       done;
    logic       div0;

    int total;
    int bad;

    div_restoring_ctrl #(.N(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div0      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns the number of edges after the accepting edge at which done is first seen.
    task automatic run_div(input logic [2:0] dd, input logic [2:0] dv, input bit chk_busy,
                           output int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            if (chk_busy) chk("busy_run", busy, 1);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int t[3];
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        #1;
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", div0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 6/3: latency, busy window and one-cycle done pulse.
        run_div(3'd6, 3'd3, 1'b1, lat);
        chk("lat_6_3", lat, 7);
        chk("q_6_3", quotient, 2);
        chk("r_6_3", remainder, 0);
        chk("div0_6_3", div0, 0);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_pulse_end", done, 0);
        repeat (3) @(negedge clk);
        chk("hold_q_6_3", quotient, 2);

        run_div(3'd7, 3'd2, 1'b0, lat);
        chk("q_7_2", quotient, 3);
        chk("r_7_2", remainder, 1);

        run_div(3'd5, 3'd7, 1'b0, lat);
        chk("q_5_7", quotient, 0);
        chk("r_5_7", remainder, 5);

        for (int dd = 0; dd < 8; dd++) begin
            for (int dv = 1; dv < 8; dv++) begin
                run_div(3'(dd), 3'(dv), 1'b0, lat);
                chk($sformatf("exq_%0d_%0d", dd, dv), quotient, dd / dv);
                chk($sformatf("exr_%0d_%0d", dd, dv), remainder, dd % dv);
                chk($sformatf("exz_%0d_%0d", dd, dv), div0, 0);
            end
        end

        // Divide by zero.
        run_div(3'd7, 3'd0, 1'b0, lat);
`ifdef DIV0_FAST_EN
        chk("lat_7_0", lat, 2);
        chk("div0_7_0", div0, 1);
`else
        chk("lat_7_0", lat, 7);
        chk("div0_7_0", div0, 0);
`endif
        chk("q_7_0", quotient, 7);
        chk("r_7_0", remainder, 7);

        // Start reasserted mid-operation must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 3'd6;
        divisor  = 3'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 3'd7;
        divisor  = 3'd1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        lat   = 0;
        for (int e = 4; e <= 14; e++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                lat = e;
            end
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_edge", lat, 7);
        chk("ign_q", quotient, 2);
        chk("ign_r", remainder, 0);

        // Reset mid-operation aborts with no done.
        @(negedge clk);
        start    = 1'b1;
        dividend = 3'd7;
        divisor  = 3'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quot", quotient, 0);
        chk("abort_rem", remainder, 0);
        chk("abort_div0", div0, 0);
        ndone = 0;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        reset = 1'b0;
        run_div(3'd4, 3'd2, 1'b1, lat);
        chk("post_rst_lat", lat, 7);
        chk("post_rst_q", quotient, 2);
        chk("post_rst_r", remainder, 0);

        // Back-to-back with start held high.
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 3'd5;
        divisor  = 3'd2;
        ndone    = 0;
        for (int k = 0; k < 40 && ndone < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                t[ndone] = k;
                ndone++;
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 3);
        chk("b2b_first", t[0], 7);
        chk("b2b_gap1", t[1] - t[0], 9);
        chk("b2b_gap2", t[2] - t[1], 9);
        chk("b2b_q", quotient, 2);
        chk("b2b_r", remainder, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
